// File: rtl/csr_file.sv
// csr_file: machine-mode CSR unit with ECALL/MRET sequencing, illegal-access detection
// and 64-bit cycle/instret counters. Commands update state on the accepting edge.
module csr_file #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          COUNTERS_EN = 1'b1,
  parameter bit          VECTORED_EN = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [2:0]      csr_cmd,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] op1_data,
  input  logic            op1_is_zero_src,
  input  logic [XLEN-1:0] pc,
  input  logic            retire,
  output logic            out_valid,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal
);

  localparam int unsigned CNT_W = 64;
  localparam int unsigned HALF  = 32;

  localparam logic [2:0] CMD_W     = 3'd1;
  localparam logic [2:0] CMD_S     = 3'd2;
  localparam logic [2:0] CMD_C     = 3'd3;
  localparam logic [2:0] CMD_ECALL = 3'd4;
  localparam logic [2:0] CMD_MRET  = 3'd5;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;

  logic             mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0]  mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0]  mepc_q, mepc_d, mcause_q, mcause_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic             out_valid_q, out_valid_d, redirect_q, redirect_d, illegal_q, illegal_d;
  logic [XLEN-1:0]  rdata_q, rdata_d, rpc_q, rpc_d;

  logic [XLEN-1:0]  mstatus_rd, mtvec_rd, rd_val, wdata;
  logic             rd_hit, rd_ro, accept, wr_req, bad;

  assign mstatus_rd = XLEN'({mpie_q, 3'b000, mie_q, 3'b000});
  assign mtvec_rd   = VECTORED_EN ? mtvec_q : {mtvec_q[XLEN-1:2], 2'b00};

  // Address decode: read value, implemented, read-only
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    rd_ro  = 1'b0;
    case (csr_addr)
      A_MSTATUS:   rd_val = mstatus_rd;
      A_MTVEC:     rd_val = mtvec_rd;
      A_MSCRATCH:  rd_val = mscratch_q;
      A_MEPC:      rd_val = mepc_q;
      A_MCAUSE:    rd_val = mcause_q;
      A_MCYCLE:    begin rd_val = mcycle_q[HALF-1:0];       rd_hit = COUNTERS_EN; end
      A_MCYCLEH:   begin rd_val = mcycle_q[CNT_W-1:HALF];   rd_hit = COUNTERS_EN; end
      A_MINSTRET:  begin rd_val = minstret_q[HALF-1:0];     rd_hit = COUNTERS_EN; end
      A_MINSTRETH: begin rd_val = minstret_q[CNT_W-1:HALF]; rd_hit = COUNTERS_EN; end
      A_MHARTID:   rd_ro = 1'b1;
      A_CYCLE:     begin rd_val = mcycle_q[HALF-1:0];   rd_hit = COUNTERS_EN; rd_ro = 1'b1; end
      A_INSTRET:   begin rd_val = minstret_q[HALF-1:0]; rd_hit = COUNTERS_EN; rd_ro = 1'b1; end
      default:     rd_hit = 1'b0;
    endcase
  end

  always_comb begin
    accept = in_valid & ~flush;
    wr_req = (csr_cmd == CMD_W) | (((csr_cmd == CMD_S) | (csr_cmd == CMD_C)) & ~op1_is_zero_src);
    bad    = ~rd_hit | (rd_ro & wr_req);

    wdata = op1_data;
    if (csr_cmd == CMD_S) wdata = rd_val | op1_data;
    if (csr_cmd == CMD_C) wdata = rd_val & ~op1_data;

    mie_d       = mie_q;
    mpie_d      = mpie_q;
    mtvec_d     = mtvec_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mcycle_d    = mcycle_q + 1'b1;
    minstret_d  = minstret_q + CNT_W'(retire);
    out_valid_d = accept;
    redirect_d  = 1'b0;
    illegal_d   = 1'b0;
    rdata_d     = rdata_q;
    rpc_d       = rpc_q;

    if (accept) begin
      case (csr_cmd)
        CMD_W, CMD_S, CMD_C: begin
          rdata_d   = bad ? '0 : rd_val;
          illegal_d = bad;
          // A written half overrides the increment; the other half keeps it
          if (wr_req && !bad) begin
            case (csr_addr)
              A_MSTATUS:   begin mie_d = wdata[3]; mpie_d = wdata[7]; end
              A_MTVEC:     mtvec_d = VECTORED_EN ? wdata : {wdata[XLEN-1:2], 2'b00};
              A_MSCRATCH:  mscratch_d = wdata;
              A_MEPC:      mepc_d = {wdata[XLEN-1:2], 2'b00};
              A_MCAUSE:    mcause_d = wdata;
              A_MCYCLE:    mcycle_d[HALF-1:0] = wdata;
              A_MCYCLEH:   mcycle_d[CNT_W-1:HALF] = wdata;
              A_MINSTRET:  minstret_d[HALF-1:0] = wdata;
              A_MINSTRETH: minstret_d[CNT_W-1:HALF] = wdata;
              default: ;
            endcase
          end
        end
        CMD_ECALL: begin
          mepc_d     = {pc[XLEN-1:2], 2'b00};
          mcause_d   = XLEN'(11);
          mpie_d     = mie_q;
          mie_d      = 1'b0;
          redirect_d = 1'b1;
          rpc_d      = {mtvec_q[XLEN-1:2], 2'b00};
          rdata_d    = '0;
        end
        CMD_MRET: begin
          mie_d      = mpie_q;
          mpie_d     = 1'b1;
          redirect_d = 1'b1;
          rpc_d      = mepc_q;
          rdata_d    = '0;
        end
        default: ;
      endcase
    end

    if (!COUNTERS_EN) begin
      mcycle_d   = '0;
      minstret_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mtvec_q     <= MTVEC_RESET;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
      out_valid_q <= 1'b0;
      redirect_q  <= 1'b0;
      illegal_q   <= 1'b0;
      rdata_q     <= '0;
      rpc_q       <= '0;
    end else begin
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      mtvec_q     <= mtvec_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      out_valid_q <= out_valid_d;
      redirect_q  <= redirect_d;
      illegal_q   <= illegal_d;
      rdata_q     <= rdata_d;
      rpc_q       <= rpc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign csr_rdata   = rdata_q;
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign illegal     = illegal_q;

endmodule
